// File: rtl/booth_mul_core.sv
// booth_mul_core: sequential signed Booth multiplier.
// Default build uses radix-2 Booth recoding (WIDTH RUN cycles).
// Defining BOOTH_MUL_RADIX4_EN selects radix-4 (modified Booth) recoding,
// which needs ceil(WIDTH/2) RUN cycles; results and interface are identical.
// m carries the low 2*WIDTH-1 bits of the exact product, ov flags the case
// where the product does not fit in that width.
module booth_mul_core #(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-2:0]   m,
    output logic                 ov,
    output logic                 busy,
    output logic                 done
);

`ifdef BOOTH_MUL_RADIX4_EN
    // Multiplier sign-extended to an even width so it splits into bit pairs;
    // accumulator has room for +/-2A.
    localparam int QW    = WIDTH + (WIDTH % 2);
    localparam int AW    = WIDTH + 2;
    localparam int STEPS = QW / 2;
`else
    // One multiplier bit per step; one guard bit so -(most negative A) fits.
    localparam int QW    = WIDTH;
    localparam int AW    = WIDTH + 1;
    localparam int STEPS = WIDTH;
`endif
    localparam int RW = AW + QW + 1;
    localparam int CW = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          acc_q, acc_d;
    logic [QW-1:0]          q_q, q_d;
    logic                   qm1_q, qm1_d;
    logic [WIDTH-1:0]       mcand_q, mcand_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*WIDTH-2:0]     m_q, m_d;
    logic                   ov_q, ov_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [AW-1:0]          a_ext_s;
    logic [AW-1:0]          a_dbl_s;
    logic [QW-1:0]          b_ext_s;
    logic [AW-1:0]          sum_s;
    logic [RW-1:0]          pre_shift_s;
    logic [RW-1:0]          post_shift_s;
    logic [AW+QW-1:0]       full_prod_s;
    logic                   prod_unused_s;

    // Sign extension of the operands and the combined acc/Q product view.
    assign a_ext_s       = AW'($signed(mcand_q));
    assign a_dbl_s       = {a_ext_s[AW-2:0], 1'b0};
    assign b_ext_s       = QW'($signed(B));
    assign full_prod_s   = {acc_q, q_q};
    assign prod_unused_s = ^full_prod_s[AW+QW-1:2*WIDTH-1];

    // One Booth recoding step: add the selected multiple of A, then shift right arithmetically.
    always_comb begin
        sum_s = acc_q;
`ifdef BOOTH_MUL_RADIX4_EN
        case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: sum_s = acc_q + a_ext_s;
            3'b011:         sum_s = acc_q + a_dbl_s;
            3'b100:         sum_s = acc_q - a_dbl_s;
            3'b101, 3'b110: sum_s = acc_q - a_ext_s;
            default:        sum_s = acc_q;
        endcase
        pre_shift_s  = {sum_s, q_q, qm1_q};
        post_shift_s = {{2{pre_shift_s[RW-1]}}, pre_shift_s[RW-1:2]};
`else
        case ({q_q[0], qm1_q})
            2'b01:   sum_s = acc_q + a_ext_s;
            2'b10:   sum_s = acc_q - a_ext_s;
            default: sum_s = acc_q;
        endcase
        pre_shift_s  = {sum_s, q_q, qm1_q};
        post_shift_s = {pre_shift_s[RW-1], pre_shift_s[RW-1:1]};
`endif
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        ov_d    = ov_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = A;
                    q_d     = b_ext_s;
                    qm1_d   = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                {acc_d, q_d, qm1_d} = post_shift_s;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(STEPS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                m_d     = full_prod_s[2*WIDTH-2:0];
                ov_d    = full_prod_s[2*WIDTH-1] ^ full_prod_s[2*WIDTH-2];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything and aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            mcand_q <= '0;
            cnt_q   <= '0;
            m_q     <= '0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign m    = m_q;
    assign ov   = ov_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_booth_mul_core.sv
// Testbench for booth_mul_core: directed vectors, exhaustive 6x6 sweep,
// reset abort, ignored re-start and randomized operations against an
// arithmetic reference product.
module tb_booth_mul_core;

    localparam int W = 6;
`ifdef BOOTH_MUL_RADIX4_EN
    localparam int LAT = ((W + 1) / 2) + 1;
`else
    localparam int LAT = W + 1;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic [2*W-2:0]   m;
    logic             ov;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    booth_mul_core #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .m     (m),
        .ov    (ov),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        longint pa;
        longint pb;
        longint p;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        p  = pa * pb;
        return p[2*W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one multiplication; inj >= 0 re-pulses start that many cycles after capture.
    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int inj, input bit tail);
        logic [2*W-1:0] p;
        logic [2*W-2:0] prev_m;
        int n;
        int pulses;
        p      = ref_prod(a, b);
        prev_m = m;
        A      = a;
        B      = b;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        A      = W'($urandom);
        B      = W'($urandom);
        if (tail) chk("busy_after_capture", {31'd0, busy}, 32'd1);
        n = 0;
        while (done !== 1'b1 && n < LAT + 4) begin
            if (n == inj) begin
                start = 1'b1;
                A     = W'($urandom);
                B     = W'($urandom);
            end else begin
                start = 1'b0;
            end
            if (tail) chk("m_hold_run", {21'd0, m}, {21'd0, prev_m});
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("latency", n, LAT);
        chk("m", {21'd0, m}, {21'd0, p[2*W-2:0]});
        chk("ov", {31'd0, ov}, {31'd0, p[2*W-1] ^ p[2*W-2]});
        if (tail) begin
            chk("busy_at_done", {31'd0, busy}, 32'd0);
            pulses = 0;
            for (int k = 0; k < LAT + 2; k++) begin
                @(posedge clk); #1;
                if (done === 1'b1) pulses++;
            end
            chk("no_extra_done", pulses, 0);
            chk("busy_idle", {31'd0, busy}, 32'd0);
            chk("m_held_idle", {21'd0, m}, {21'd0, p[2*W-2:0]});
        end
    endtask

    initial begin
        int pulses;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_m", {21'd0, m}, 32'd0);
        chk("rst_ov", {31'd0, ov}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors with fixed expected constants.
        do_mul(6'd3, 6'd5, -1, 1'b1);
        chk("spec_3x5_m", {21'd0, m}, 32'h00F);
        chk("spec_3x5_ov", {31'd0, ov}, 32'd0);
        do_mul(6'h3F, 6'h3F, -1, 1'b1);
        chk("spec_m1xm1_m", {21'd0, m}, 32'h001);
        chk("spec_m1xm1_ov", {31'd0, ov}, 32'd0);
        do_mul(6'd31, 6'h20, -1, 1'b1);
        chk("spec_31xm32_m", {21'd0, m}, 32'h420);
        chk("spec_31xm32_ov", {31'd0, ov}, 32'd0);
        do_mul(6'h20, 6'h20, -1, 1'b1);
        chk("spec_m32xm32_m", {21'd0, m}, 32'h400);
        chk("spec_m32xm32_ov", {31'd0, ov}, 32'd1);
        do_mul(6'h20, 6'd31, -1, 1'b1);
        chk("spec_m32x31_m", {21'd0, m}, 32'h420);
        chk("spec_m32x31_ov", {31'd0, ov}, 32'd0);

        // Start re-pulsed while busy, and during the final busy cycle.
        do_mul(6'd3, 6'd5, 2, 1'b1);
        chk("restart_m", {21'd0, m}, 32'h00F);
        do_mul(6'h2B, 6'd9, LAT - 1, 1'b1);
        do_mul(6'd7, 6'h3D, 0, 1'b1);

        // Reset asserted during the third RUN cycle aborts the operation.
        A     = 6'd7;
        B     = 6'h3A;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_m", {21'd0, m}, 32'd0);
        chk("abort_ov", {31'd0, ov}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < LAT + 3; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        do_mul(6'd11, 6'h3A, -1, 1'b1);

        // Exhaustive sweep of all operand pairs.
        for (int i = 0; i < (1 << W); i++) begin
            for (int j = 0; j < (1 << W); j++) begin
                do_mul(W'(i), W'(j), -1, 1'b0);
            end
        end

        // Randomized operations with random idle gaps and occasional re-starts.
        for (int r = 0; r < 200; r++) begin
            int gap;
            int inj;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LAT - 1)) : -1;
            do_mul(W'($urandom), W'($urandom), inj, (r % 20) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
